// File: rtl/lcd_frame_streamer.sv
// Snapshots the processor lcd_* debug bus and streams one 2x16 ASCII frame
// per start pulse or refresh tick over a valid/ready character interface.
module lcd_frame_streamer #(
    parameter int NBITS          = 8,
    parameter int NREGS          = 32,
    parameter int REFRESH_CYCLES = 0,
    parameter int PAGE_W         = 3
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              start,
    input  logic [PAGE_W-1:0] page,
    input  logic [NBITS-1:0]  lcd_pc,
    input  logic [31:0]       lcd_instruction,
    input  logic [NBITS-1:0]  lcd_SrcA,
    input  logic [NBITS-1:0]  lcd_SrcB,
    input  logic [NBITS-1:0]  lcd_ALUResult,
    input  logic [NBITS-1:0]  lcd_Result,
    input  logic [NBITS-1:0]  lcd_WriteData,
    input  logic [NBITS-1:0]  lcd_ReadData,
    input  logic              lcd_MemWrite,
    input  logic              lcd_Branch,
    input  logic              lcd_MemtoReg,
    input  logic              lcd_RegWrite,
    input  logic [NBITS-1:0]  lcd_registrador [0:NREGS-1],
    output logic              char_valid,
    input  logic              char_ready,
    output logic [7:0]        char_data,
    output logic              char_row,
    output logic [3:0]        char_col,
    output logic              busy,
    output logic              frame_done
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_cnt;
    logic [NBITS-1:0]  r_pc, r_srca, r_srcb, r_alu, r_res, r_wd, r_rd;
    logic [31:0]       r_instr;
    logic [3:0]        r_flags;
    logic [NBITS-1:0]  r_regs [0:NREGS-1];
    logic [PAGE_W-1:0] r_page;
    logic              r_row;
    logic [3:0]        r_col;
    logic              r_done;

    logic       w_trigger, w_xfer, w_last, w_regview;
    logic [6:0] w_pg, w_base, w_ridx;
    logic [3:0] w_tens, w_ones, w_sh;
    logic [1:0] w_k;
    logic [7:0] w_rbyte, w_byte, w_lit;
    logic       w_hex, w_hi;
    logic [3:0] w_nib;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign w_trigger = (r_state == S_IDLE) &&
        (start || (REFRESH_CYCLES > 0 && r_cnt == 32'(REFRESH_CYCLES - 1)));
    assign w_xfer = (r_state == S_EMIT) && char_ready;
    assign w_last = w_xfer && r_row && (r_col == 4'd15);

    always_ff @(posedge clk_2) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        char_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: if (w_trigger) w_next = S_EMIT;
            S_EMIT: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pc    <= '0;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_alu   <= '0;
            r_res   <= '0;
            r_wd    <= '0;
            r_rd    <= '0;
            r_instr <= '0;
            r_flags <= '0;
            r_page  <= '0;
            r_row   <= 1'b0;
            r_col   <= 4'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_done <= w_last;
            if (r_state == S_IDLE) begin
                r_cnt <= w_trigger ? 32'd0 : r_cnt + 32'd1;
                if (w_trigger) begin
                    r_pc    <= lcd_pc;
                    r_srca  <= lcd_SrcA;
                    r_srcb  <= lcd_SrcB;
                    r_alu   <= lcd_ALUResult;
                    r_res   <= lcd_Result;
                    r_wd    <= lcd_WriteData;
                    r_rd    <= lcd_ReadData;
                    r_instr <= lcd_instruction;
                    r_flags <= {lcd_MemWrite, lcd_Branch,
                                lcd_MemtoReg, lcd_RegWrite};
                    r_page  <= page;
                    r_row   <= 1'b0;
                    r_col   <= 4'd0;
                    for (int i = 0; i < NREGS; i++)
                        r_regs[i] <= lcd_registrador[i];
                end
            end
            // col wraps 15->0; after the last char both row and col are 0
            if (w_xfer) begin
                r_col <= r_col + 4'd1;
                if (r_col == 4'd15) r_row <= ~r_row;
            end
        end
    end

    assign w_regview = (r_page != '0) && (r_page <= PAGE_W'(NREGS / 8));
    assign w_pg      = 7'(r_page);
    assign w_base    = ((w_pg - 7'd1) << 3) + (r_row ? 7'd4 : 7'd0);
    assign w_tens    = 4'(w_base / 7'd10);
    assign w_ones    = 4'(w_base % 7'd10);
    assign w_k       = 2'((r_col - 4'd4) / 4'd3);
    assign w_ridx    = w_base + {5'd0, w_k};
    assign w_rbyte   = r_regs[w_ridx[IW-1:0]];
    assign w_sh      = 4'd10 - r_col;

    always_comb begin
        w_hex  = 1'b0;
        w_hi   = 1'b0;
        w_byte = 8'h00;
        w_lit  = 8'h20;
        if (w_regview) begin
            case (r_col)
                4'd0:  w_lit = "x";
                4'd1:  begin w_hex = 1'b1; w_byte = {4'h0, w_tens}; end
                4'd2:  begin w_hex = 1'b1; w_byte = {4'h0, w_ones}; end
                4'd4, 4'd7, 4'd10, 4'd13:
                       begin w_hex = 1'b1; w_hi = 1'b1; w_byte = w_rbyte; end
                4'd5, 4'd8, 4'd11, 4'd14:
                       begin w_hex = 1'b1; w_byte = w_rbyte; end
                default: w_lit = 8'h20;
            endcase
        end else if (!r_row) begin
            case (r_col)
                4'd0:  begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_pc; end
                4'd1:  begin w_hex = 1'b1; w_byte = r_pc; end
                4'd2, 4'd11: w_lit = 8'h20;
                4'd12: w_lit = r_flags[3] ? "W" : "-";
                4'd13: w_lit = r_flags[2] ? "B" : "-";
                4'd14: w_lit = r_flags[1] ? "M" : "-";
                4'd15: w_lit = r_flags[0] ? "R" : "-";
                default: begin
                    w_hex  = 1'b1;
                    w_byte = {4'h0, r_instr[{w_sh[2:0], 2'b00} +: 4]};
                end
            endcase
        end else begin
            case (r_col)
                4'd0:  begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_srca; end
                4'd1:  begin w_hex = 1'b1; w_byte = r_srca; end
                4'd2:  begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_srcb; end
                4'd3:  begin w_hex = 1'b1; w_byte = r_srcb; end
                4'd5:  begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_alu; end
                4'd6:  begin w_hex = 1'b1; w_byte = r_alu; end
                4'd8:  begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_res; end
                4'd9:  begin w_hex = 1'b1; w_byte = r_res; end
                4'd11: begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_wd; end
                4'd12: begin w_hex = 1'b1; w_byte = r_wd; end
                4'd14: begin w_hex = 1'b1; w_hi = 1'b1; w_byte = r_rd; end
                4'd15: begin w_hex = 1'b1; w_byte = r_rd; end
                default: w_lit = 8'h20;
            endcase
        end
    end

    assign w_nib      = w_hi ? w_byte[7:4] : w_byte[3:0];
    assign char_data  = (r_state == S_EMIT) ? (w_hex ? f_hex(w_nib) : w_lit) : 8'h00;
    assign char_row   = r_row;
    assign char_col   = r_col;
    assign frame_done = r_done;
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer: datapath and register pages,
// backpressure, snapshot isolation, auto-refresh and mid-frame reset.
module tb_lcd_frame_streamer;
    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic        reset = 1'b1, start = 1'b0;
    logic        ar_reset = 1'b1, ar_start = 1'b0, ar_ready = 1'b1;
    logic [2:0]  page = 3'd0;
    logic [7:0]  pc, srca, srcb, alu, res, wd, rd;
    logic [31:0] instr;
    logic        mw, br, mr, rw;
    logic [7:0]  regs [0:31];
    logic        char_ready = 1'b1;

    logic       char_valid, char_row, busy, frame_done;
    logic [7:0] char_data;
    logic [3:0] char_col;
    logic       ar_valid, ar_row, ar_busy, ar_done;
    logic [7:0] ar_data;
    logic [3:0] ar_col;

    int checks = 0, failures = 0;

    logic [7:0] cap_d [0:63];
    logic       cap_r [0:63];
    logic [3:0] cap_c [0:63];
    int         cap_n, cap_last, cap_donec;
    bit         cap_done;
    logic [7:0] hold_d [0:7];
    logic       hold_r [0:7], hold_v [0:7];
    logic [3:0] hold_c [0:7];

    string s_p0  = {"12 34567890 W-M-", "abcd ef 11 22 33"};
    string s_pg1 = {"x00 00 11 22 33 ", "x04 44 55 66 77 "};
    string s_pg4 = {"x24 98 a9 ba cb ", "x28 dc ed fe 0f "};

    lcd_frame_streamer #(.NBITS(8), .NREGS(32), .REFRESH_CYCLES(0), .PAGE_W(3)) dut (
        .clk_2(clk_2), .reset(reset), .start(start), .page(page),
        .lcd_pc(pc), .lcd_instruction(instr),
        .lcd_SrcA(srca), .lcd_SrcB(srcb), .lcd_ALUResult(alu),
        .lcd_Result(res), .lcd_WriteData(wd), .lcd_ReadData(rd),
        .lcd_MemWrite(mw), .lcd_Branch(br), .lcd_MemtoReg(mr), .lcd_RegWrite(rw),
        .lcd_registrador(regs),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .char_row(char_row), .char_col(char_col), .busy(busy),
        .frame_done(frame_done)
    );

    lcd_frame_streamer #(.NBITS(8), .NREGS(32), .REFRESH_CYCLES(10), .PAGE_W(3)) dut_ar (
        .clk_2(clk_2), .reset(ar_reset), .start(ar_start), .page(page),
        .lcd_pc(pc), .lcd_instruction(instr),
        .lcd_SrcA(srca), .lcd_SrcB(srcb), .lcd_ALUResult(alu),
        .lcd_Result(res), .lcd_WriteData(wd), .lcd_ReadData(rd),
        .lcd_MemWrite(mw), .lcd_Branch(br), .lcd_MemtoReg(mr), .lcd_RegWrite(rw),
        .lcd_registrador(regs),
        .char_valid(ar_valid), .char_ready(ar_ready), .char_data(ar_data),
        .char_row(ar_row), .char_col(ar_col), .busy(ar_busy),
        .frame_done(ar_done)
    );

    task automatic tick;
        @(negedge clk_2);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records every accepted character until frame_done; optional stall/poke
    task automatic capture(input int stall_idx, input int stall_len, input int poke_idx);
        int cyc;
        bit stalled, poked;
        cap_n = 0; cap_done = 0; cap_last = -1; cap_donec = -1;
        stalled = 0; poked = 0; cyc = 0;
        for (int i = 0; i < 64; i++) cap_d[i] = 8'hxx;
        while (cyc < 300) begin
            if (frame_done) begin
                cap_done = 1; cap_donec = cyc;
                break;
            end
            start = 1'b0;
            if (char_valid && cap_n == stall_idx && !stalled) begin
                stalled = 1;
                char_ready = 1'b0;
                for (int i = 0; i < stall_len; i++) begin
                    tick(); cyc++;
                    hold_d[i] = char_data; hold_r[i] = char_row;
                    hold_c[i] = char_col;  hold_v[i] = char_valid;
                end
                char_ready = 1'b1;
            end
            if (char_valid && cap_n == poke_idx && !poked) begin
                poked = 1;
                pc = 8'hff;
                start = 1'b1;
            end
            if (char_valid && char_ready && cap_n < 64) begin
                cap_d[cap_n] = char_data;
                cap_r[cap_n] = char_row;
                cap_c[cap_n] = char_col;
                cap_last = cyc;
                cap_n++;
            end
            tick(); cyc++;
        end
        start = 1'b0;
    endtask

    task automatic set_datapath;
        pc = 8'h12; instr = 32'h34567890;
        srca = 8'hab; srcb = 8'hcd; alu = 8'hef;
        res = 8'h11; wd = 8'h22; rd = 8'h33;
        mw = 1'b1; br = 1'b0; mr = 1'b1; rw = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b want 0 0 0",
                     char_valid, busy, frame_done);
        end
        checks++;
        if (char_data !== 8'h00 || char_row !== 1'b0 || char_col !== 4'd0) begin
            failures++;
            $display("FAIL reset_fields: data=%h row=%b col=%0d want 00 0 0",
                     char_data, char_row, char_col);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (char_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_auto: valid=%b want 0", char_valid);
        end
    endtask

    task automatic test_page0;
        page = 3'd0;
        set_datapath();
        tick();
        pulse_start();
        checks++;
        if (char_valid !== 1'b1 || busy !== 1'b1 || char_row !== 1'b0 || char_col !== 4'd0) begin
            failures++;
            $display("FAIL p0_first_valid: valid=%b busy=%b row=%b col=%0d want 1 1 0 0",
                     char_valid, busy, char_row, char_col);
        end
        capture(-1, 0, -1);
        checks++;
        if (cap_n !== 32 || !cap_done) begin
            failures++;
            $display("FAIL p0_count: xfers=%0d done=%0d want 32 1", cap_n, cap_done);
        end
        checks++;
        if (cap_donec !== cap_last + 1) begin
            failures++;
            $display("FAIL p0_done_latency: done at %0d last xfer at %0d want +1",
                     cap_donec, cap_last);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_d[i] !== s_p0[i] || cap_r[i] !== 1'(i / 16) || cap_c[i] !== 4'(i % 16)) begin
                failures++;
                $display("FAIL p0_char%0d: got %h r%b c%0d want %h r%0d c%0d",
                         i, cap_d[i], cap_r[i], cap_c[i], s_p0[i], i / 16, i % 16);
            end
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || char_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL p0_after: done=%b valid=%b busy=%b want 0 0 0",
                     frame_done, char_valid, busy);
        end
    endtask

    task automatic test_reg_pages;
        string exp;
        bit ok;
        for (int p = 0; p < 3; p++) begin
            page = (p == 0) ? 3'd1 : (p == 1) ? 3'd4 : 3'd7;
            exp  = (p == 0) ? s_pg1 : (p == 1) ? s_pg4 : s_p0;
            tick();
            pulse_start();
            capture(-1, 0, -1);
            checks++;
            if (cap_n !== 32 || !cap_done) begin
                failures++;
                $display("FAIL page%0d_count: xfers=%0d done=%0d want 32 1", page, cap_n, cap_done);
            end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (cap_d[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL page%0d_char%0d: got %h want %h", page, i, cap_d[i], exp[i]);
                end
            end
        end
        page = 3'd0;
    endtask

    task automatic test_backpressure;
        tick();
        pulse_start();
        capture(3, 5, -1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (hold_v[i] !== 1'b1 || hold_d[i] !== 8'h33 || hold_r[i] !== 1'b0 || hold_c[i] !== 4'd3) begin
                failures++;
                $display("FAIL bp_hold%0d: v=%b data=%h row=%b col=%0d want 1 33 0 3",
                         i, hold_v[i], hold_d[i], hold_r[i], hold_c[i]);
            end
        end
        checks++;
        if (cap_n !== 32 || !cap_done) begin
            failures++;
            $display("FAIL bp_count: xfers=%0d done=%0d want 32 1", cap_n, cap_done);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_d[i] !== s_p0[i] || cap_c[i] !== 4'(i % 16)) begin
                failures++;
                $display("FAIL bp_char%0d: got %h c%0d want %h c%0d",
                         i, cap_d[i], cap_c[i], s_p0[i], i % 16);
            end
        end
    endtask

    task automatic test_snapshot;
        int extra;
        tick();
        pulse_start();
        capture(-1, 0, 5);
        checks++;
        if (cap_n !== 32 || !cap_done) begin
            failures++;
            $display("FAIL snap_count: xfers=%0d done=%0d want 32 1", cap_n, cap_done);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_d[i] !== s_p0[i]) begin
                failures++;
                $display("FAIL snap_char%0d: got %h want %h", i, cap_d[i], s_p0[i]);
            end
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (char_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL snap_no_second_frame: valid cycles=%0d want 0", extra);
        end
        pc = 8'h12;
    endtask

    task automatic test_reset_mid;
        int n;
        tick();
        pulse_start();
        n = 0;
        while (!(char_valid && char_row == 1'b1 && char_col == 4'd2) && n < 60) begin
            tick(); n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL mid_reach: row1 col2 not reached, row=%b col=%0d", char_row, char_col);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort: valid=%b busy=%b done=%b want 0 0 0",
                     char_valid, busy, frame_done);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (frame_done !== 1'b0 || char_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_done: done=%b valid=%b want 0 0", frame_done, char_valid);
        end
        pulse_start();
        capture(-1, 0, -1);
        checks++;
        if (cap_n !== 32 || !cap_done || cap_r[0] !== 1'b0 || cap_c[0] !== 4'd0) begin
            failures++;
            $display("FAIL mid_restart: xfers=%0d done=%0d first r%b c%0d want 32 1 r0 c0",
                     cap_n, cap_done, cap_r[0], cap_c[0]);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_d[i] !== s_p0[i]) begin
                failures++;
                $display("FAIL mid_char%0d: got %h want %h", i, cap_d[i], s_p0[i]);
            end
        end
    endtask

    task automatic test_auto_refresh;
        int n, x, m;
        ar_reset = 1'b1;
        tick();
        ar_reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (!ar_valid && n < 50) begin tick(); n++; end
            checks++;
            if (n !== 10) begin
                failures++;
                $display("FAIL ar_gap%0d: idle cycles=%0d want 10", r, n);
            end
            x = 0; m = 0;
            while (!ar_done && m < 100) begin
                if (ar_valid) x++;
                tick(); m++;
            end
            checks++;
            if (x !== 32 || !ar_done) begin
                failures++;
                $display("FAIL ar_frame%0d: xfers=%0d done=%b want 32 1", r, x, ar_done);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 8'((i * 17) % 256);
        set_datapath();
        test_reset();
        test_page0();
        test_reg_pages();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        test_auto_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Consumer side of the lcd_* debug bus that the processor top drives: pc, instruction, datapath values, control flags and the register file.
- On a start pulse or an auto-refresh tick, it snapshots the whole bus and serialises one 2x16 ASCII character frame.
- Characters go out over a valid/ready stream to the character-LCD / display backend.
- A page input selects either the datapath view or one 8-register view of the register file.

Parameters:
- NBITS, 8, width of every lcd_* byte field. Only 8 is supported: each field renders as 2 hex digits.
- NREGS, 32, register count. Must be a multiple of 8 and no greater than 96.
- REFRESH_CYCLES, 0, idle cycles between automatic frames. 0 disables auto-refresh.
- PAGE_W, 3, width of page; must satisfy 2^PAGE_W > NREGS/8.

Ports:
- clk_2  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request, sampled in IDLE only.
- page  in  PAGE_W  0 = datapath view; p in 1..NREGS/8 = registers 8(p-1)..8(p-1)+7. Values above NREGS/8 are treated as 0.
- lcd_pc, lcd_SrcA, lcd_SrcB, lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData  in  NBITS each  datapath values.
- lcd_instruction  in  32  current instruction.
- lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite  in  1 each  control flags.
- lcd_registrador  in  NBITS x [0:NREGS-1]  register file contents.
- char_valid  out  1  char_data, char_row and char_col are valid.
- char_ready  in  1  sink accepts the character.
- char_data  out  8  ASCII code.
- char_row  out  1  0 = top row, 1 = bottom row.
- char_col  out  4  column 0..15.
- busy  out  1  high in EMIT.
- frame_done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- FSM states: IDLE, EMIT.
- Reset: state IDLE, all outputs 0, refresh counter 0, snapshot registers 0. Reset mid-frame aborts the frame with no frame_done.
- IDLE: the refresh counter increments each cycle. A trigger is start=1, or REFRESH_CYCLES>0 with the counter at REFRESH_CYCLES-1. On the trigger edge:
  - every lcd_* input and page are captured into snapshot registers;
  - the counter clears;
  - state goes to EMIT with row=0, col=0.
  - char_valid rises the cycle after the trigger edge.
- EMIT:
  - char_valid=1, busy=1.
  - A transfer occurs on any edge with char_valid & char_ready.
  - char_data, char_row and char_col stay stable until the transfer.
  - Order: row 0 cols 0..15, then row 1 cols 0..15; 32 transfers per frame.
  - After the transfer of (row 1, col 15): state returns to IDLE, char_valid drops, and frame_done=1 for exactly one cycle.
  - start is ignored while in EMIT.
  - Input changes during EMIT do not affect the frame, which renders only from the snapshot.
- Hex digit encoding: 0-9 map to 0x30-0x39; a-f map to lowercase 0x61-0x66. Byte fields print high nibble first. Space is 0x20.
- Page 0 layout:
  - Row 0: cols 0-1 pc; col 2 space; cols 3-10 instruction, 8 hex digits with the MSB nibble first; col 11 space; cols 12-15 flags.
  - Flag characters: 'W' if MemWrite, 'B' if Branch, 'M' if MemtoReg, 'R' if RegWrite; each flag prints '-' (0x2D) when 0.
  - Row 1: cols 0-1 SrcA, cols 2-3 SrcB, col 4 space, cols 5-6 ALUResult, col 7 space, cols 8-9 Result, col 10 space, cols 11-12 WriteData, col 13 space, cols 14-15 ReadData.
- Register page p, with base b = 8(p-1) + 4*row:
  - col 0 'x'; cols 1-2 decimal b, two digits with a leading zero; col 3 space;
  - cols 4-5, 7-8, 10-11, 13-14 hold regs b..b+3 in hex;
  - cols 6, 9, 12, 15 are spaces.

Test Plan:
- Page 0 snapshot: page=0, pc=0x12, instr=0x34567890, SrcA..ReadData = ab, cd, ef, 11, 22, 33, flags W=1 B=0 M=1 R=0, start pulse, char_ready=1 → 32 chars "12 34567890 W-M-" then "abcd ef 11 22 33". frame_done pulses 1 cycle after the last transfer; first char_valid appears 1 cycle after start.
- Register pages: reg[i] = (i*17) mod 256.
  - page=1 → "x00 00 11 22 33 " then "x04 44 55 66 77 ".
  - page=4 → row 0 "x24 98 a9 ba cb ".
  - page=7 → renders as page 0.
- Backpressure: char_ready=0 for 5 cycles at row 0 col 3 → char_data=0x33 ('3'), row=0, col=3 held stable; no skipped or duplicated characters; the frame completes with exactly 32 transfers.
- Snapshot isolation: change pc to 0xff and pulse start at row 0 col 5 → the current frame still prints "12"; the extra start is ignored; no second frame follows.
- Auto-refresh: REFRESH_CYCLES=10, start=0 → a frame begins after 10 idle cycles and again 10 idle cycles after each frame_done.
- Reset mid-frame at row 1 col 2 → next cycle char_valid=0, busy=0, no frame_done; a subsequent start emits a full frame from row 0 col 0.
